// File: rtl/mux_sel_ctrl_pkg.sv
// Shared types and constants for the project-mux select sequencer.
package mux_pkg;

  localparam int ADDR_W = 5;
  localparam int OW_W   = 24;

  localparam logic [ADDR_W-1:0] IDLE_ADDR = 5'd31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    SETTLE = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  // An address is legal if it names a populated slot or is the parking address.
  function automatic logic is_legal_addr(input logic [ADDR_W-1:0] addr,
                                         input int num_proj);
    return (addr == IDLE_ADDR) || (int'(addr) < num_proj);
  endfunction

endpackage

// File: rtl/mux_sel_ctrl_phase_timer.sv
// Loadable 8-bit down-counter that times both the break gap and the settle phase.
module mux_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       zero
);

  logic [7:0] count;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign value = count;
  assign zero  = (count == 8'd0);

endmodule

// File: rtl/mux_sel_ctrl.sv
// Break-before-make sequencer owning the project mux address.
// Parks on IDLE_ADDR for a gap, applies the new address, waits for it to
// settle, then reports the project live and snapshots its output word.
module mux_sel_ctrl
  import mux_pkg::*;
#(
  parameter int NUM_PROJ      = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mux_addr,
  output logic              active,
  output logic [ADDR_W-1:0] cur_addr,
  input  logic [OW_W-1:0]   ow_in,
  output logic [OW_W-1:0]   ow_q
);

  localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] target, target_next;
  logic [ADDR_W-1:0] mux_addr_next, cur_addr_next;
  logic              active_next, done_next, err_next;
  logic [OW_W-1:0]   ow_q_next;
  logic              accept;
  logic              timer_load;
  logic [7:0]        timer_load_val;
  logic              timer_zero;
  // The raw count is only interesting when debugging, so it is left dangling.
  logic [7:0]        timer_value_unused;

  mux_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .value    (timer_value_unused),
    .zero     (timer_zero)
  );

  // State and all output registers; reset parks the mux and clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      target   <= IDLE_ADDR;
      mux_addr <= IDLE_ADDR;
      cur_addr <= IDLE_ADDR;
      active   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ow_q     <= '0;
    end else begin
      state    <= state_next;
      target   <= target_next;
      mux_addr <= mux_addr_next;
      cur_addr <= cur_addr_next;
      active   <= active_next;
      done     <= done_next;
      err      <= err_next;
      ow_q     <= ow_q_next;
    end
  end

  // Next-state and next-output decisions; every register holds unless changed.
  always_comb begin
    state_next     = state;
    target_next    = target;
    mux_addr_next  = mux_addr;
    cur_addr_next  = cur_addr;
    active_next    = active;
    done_next      = 1'b0;
    err_next       = 1'b0;
    ow_q_next      = ow_q;
    timer_load     = 1'b0;
    timer_load_val = GAP_LOAD;
    req_ready      = (state == IDLE) || (state == ACTIVE);
    accept         = req_valid && req_ready;

    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_legal_addr(req_addr, NUM_PROJ)) begin
            err_next = 1'b1;
          end else if (req_addr == IDLE_ADDR) begin
            done_next = 1'b1;
          end else begin
            target_next    = req_addr;
            state_next     = GAP;
            timer_load     = 1'b1;
            timer_load_val = GAP_LOAD;
            mux_addr_next  = IDLE_ADDR;
          end
        end
      end

      ACTIVE: begin
        ow_q_next = ow_in;
        if (accept) begin
          if (!is_legal_addr(req_addr, NUM_PROJ)) begin
            err_next = 1'b1;
          end else if (req_addr == cur_addr) begin
            done_next = 1'b1;
          end else begin
            target_next    = req_addr;
            state_next     = GAP;
            timer_load     = 1'b1;
            timer_load_val = GAP_LOAD;
            mux_addr_next  = IDLE_ADDR;
            active_next    = 1'b0;
          end
        end
      end

      GAP: begin
        if (timer_zero) begin
          if (target == IDLE_ADDR) begin
            state_next    = IDLE;
            done_next     = 1'b1;
            cur_addr_next = IDLE_ADDR;
            active_next   = 1'b0;
            ow_q_next     = '0;
          end else begin
            state_next     = SETTLE;
            timer_load     = 1'b1;
            timer_load_val = SETTLE_LOAD;
            mux_addr_next  = target;
          end
        end
      end

      SETTLE: begin
        if (timer_zero) begin
          state_next    = ACTIVE;
          active_next   = 1'b1;
          done_next     = 1'b1;
          cur_addr_next = target;
          ow_q_next     = ow_in;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed cycle-by-cycle bench for mux_sel_ctrl with a reset-abort sequence.
module tb_mux_sel_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [4:0]  req_addr;
  logic        req_ready;
  logic        done;
  logic        err;
  logic [4:0]  mux_addr;
  logic        active;
  logic [4:0]  cur_addr;
  logic [23:0] ow_in;
  logic [23:0] ow_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [4:0]  addr;
    logic [23:0] ow;
    logic [4:0]  e_mux;
    logic        e_act;
    logic        e_done;
    logic        e_err;
    logic        e_rdy;
    logic [4:0]  e_cur;
    logic [23:0] e_owq;
  } vec_t;

  vec_t vecs[$];

  mux_sel_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .done      (done),
    .err       (err),
    .mux_addr  (mux_addr),
    .active    (active),
    .cur_addr  (cur_addr),
    .ow_in     (ow_in),
    .ow_q      (ow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic v, input logic [4:0] a, input logic [23:0] o,
                        input logic [4:0] m, input logic ac, input logic d,
                        input logic e, input logic r, input logic [4:0] c,
                        input logic [23:0] q);
    vec_t t;
    t.valid = v; t.addr = a; t.ow = o;
    t.e_mux = m; t.e_act = ac; t.e_done = d; t.e_err = e;
    t.e_rdy = r; t.e_cur = c; t.e_owq = q;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %0h expected %0h", name, row, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [23:0] o);
    req_valid = v;
    req_addr  = a;
    ow_in     = o;
  endtask

  task automatic checkAll(input int row, input vec_t t);
    checkOutput("mux_addr", row, 32'(mux_addr), 32'(t.e_mux));
    checkOutput("active", row, 32'(active), 32'(t.e_act));
    checkOutput("done", row, 32'(done), 32'(t.e_done));
    checkOutput("err", row, 32'(err), 32'(t.e_err));
    checkOutput("req_ready", row, 32'(req_ready), 32'(t.e_rdy));
    checkOutput("cur_addr", row, 32'(cur_addr), 32'(t.e_cur));
    checkOutput("ow_q", row, 32'(ow_q), 32'(t.e_owq));
  endtask

  initial begin
    // Select 2 from idle: two gap cycles, four settle cycles, then live.
    addVec(1, 2, 24'hA5A5A5, 31, 0, 0, 0, 1, 31, 24'h0);
    for (int i = 0; i < 2; i++) addVec(0, 2, 24'hA5A5A5, 31, 0, 0, 0, 0, 31, 24'h0);
    for (int i = 0; i < 4; i++) addVec(0, 2, 24'hA5A5A5, 2, 0, 0, 0, 0, 31, 24'h0);
    // Live on 2, switch to 1.
    addVec(1, 1, 24'hA5A5A5, 2, 1, 1, 0, 1, 2, 24'hA5A5A5);
    for (int i = 0; i < 2; i++) addVec(0, 1, 24'h123456, 31, 0, 0, 0, 0, 2, 24'hA5A5A5);
    for (int i = 0; i < 4; i++) addVec(0, 1, 24'h123456, 1, 0, 0, 0, 0, 2, 24'hA5A5A5);
    // Live on 1: reselect 1, then illegal 9.
    addVec(1, 1, 24'h123456, 1, 1, 1, 0, 1, 1, 24'h123456);
    addVec(1, 9, 24'h123456, 1, 1, 1, 0, 1, 1, 24'h123456);
    addVec(0, 9, 24'h0ABCDE, 1, 1, 0, 1, 1, 1, 24'h123456);
    // Switch to 3.
    addVec(1, 3, 24'h0ABCDE, 1, 1, 0, 0, 1, 1, 24'h0ABCDE);
    for (int i = 0; i < 2; i++) addVec(0, 3, 24'h654321, 31, 0, 0, 0, 0, 1, 24'h0ABCDE);
    for (int i = 0; i < 4; i++) addVec(0, 3, 24'h654321, 3, 0, 0, 0, 0, 1, 24'h0ABCDE);
    // Live on 3, deselect: gap only, then idle.
    addVec(1, 31, 24'h654321, 3, 1, 1, 0, 1, 3, 24'h654321);
    for (int i = 0; i < 2; i++) addVec(0, 31, 24'h654321, 31, 0, 0, 0, 0, 3, 24'h654321);
    // Idle: deselect again, then illegal 4.
    addVec(1, 31, 24'h654321, 31, 0, 1, 0, 1, 31, 24'h0);
    addVec(1, 4, 24'h654321, 31, 0, 1, 0, 1, 31, 24'h0);
    addVec(0, 4, 24'h654321, 31, 0, 0, 1, 1, 31, 24'h0);
    addVec(0, 0, 24'h654321, 31, 0, 0, 0, 1, 31, 24'h0);

    applyStimulus(0, 0, 24'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset mux_addr", -1, 32'(mux_addr), 32'd31);
    checkOutput("reset cur_addr", -1, 32'(cur_addr), 32'd31);
    checkOutput("reset active", -1, 32'(active), 32'd0);
    checkOutput("reset ow_q", -1, 32'(ow_q), 32'd0);
    rst = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(vecs[r].valid, vecs[r].addr, vecs[r].ow);
      @(negedge clk);
      checkAll(r, vecs[r]);
      @(posedge clk);
      #1;
    end

    // Request 0, then abort with reset while settling.
    applyStimulus(1, 0, 24'h777777);
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 24'h777777);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort settling mux_addr", -2, 32'(mux_addr), 32'd0);
    checkOutput("abort settling ready", -2, 32'(req_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async mux_addr", -2, 32'(mux_addr), 32'd31);
    checkOutput("async cur_addr", -2, 32'(cur_addr), 32'd31);
    checkOutput("async active", -2, 32'(active), 32'd0);
    checkOutput("async ow_q", -2, 32'(ow_q), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("post-reset done", i, 32'(done), 32'd0);
      checkOutput("post-reset err", i, 32'(err), 32'd0);
      checkOutput("post-reset mux_addr", i, 32'(mux_addr), 32'd31);
      checkOutput("post-reset ready", i, 32'(req_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
- Sequencer that owns the 5-bit project address of the project mux.
- Accepts select/deselect requests over a valid/ready handshake.
- Enforces break-before-make: the mux is parked on an idle address for a fixed gap, then the new project is selected and allowed to settle.
- Only after settling does it report the project active and register a snapshot of that project's output word.

Parameters:
- ADDR_W, 5, width of the project address.
- NUM_PROJ, 4, number of populated project slots (valid addresses 0..NUM_PROJ-1).
- IDLE_ADDR, 31, parking address; no project is selected and the mux output is zero.
- GAP_CYCLES, 2, cycles parked on IDLE_ADDR between projects; legal range 1..255.
- SETTLE_CYCLES, 4, cycles after selection before the project is active; legal range 1..255.
- OW_W, 24, width of the project output word.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_addr  in  ADDR_W  requested project; IDLE_ADDR means deselect.
- req_ready  out  1  request can be accepted this cycle.
- done  out  1  one-cycle pulse when an accepted request completes.
- err  out  1  one-cycle pulse when a request is rejected.
- mux_addr  out  ADDR_W  address driven to the project mux.
- active  out  1  selected project has settled and is live.
- cur_addr  out  ADDR_W  last completed selection (IDLE_ADDR when none).
- ow_in  in  OW_W  output word of the project mux.
- ow_q  out  OW_W  registered snapshot of ow_in.

Behaviour:
- Reset values (asynchronous, active-high rst): state IDLE, mux_addr=IDLE_ADDR, cur_addr=IDLE_ADDR, active=0, done=0, err=0, ow_q=0, counter=0.
- States:
  - IDLE: parked on IDLE_ADDR.
  - GAP: break phase.
  - SETTLE: new address applied, waiting.
  - ACTIVE: project live.
- Handshake:
  - A request is taken on a cycle where req_valid && req_ready.
  - req_ready=1 only in IDLE and ACTIVE; it is 0 in GAP and SETTLE.
  - req_addr is sampled into an internal target register on acceptance; the requester may change it afterwards.
- Legal addresses are 0..NUM_PROJ-1 and IDLE_ADDR. A request for any other address:
  - is consumed (ready is high);
  - pulses err on the next cycle;
  - leaves state and all other outputs unchanged.
- Request for the currently active address in ACTIVE: no reselection; done pulses on the next cycle.
- Request for IDLE_ADDR while in IDLE: done pulses on the next cycle.
- Legal request for a different address, accepted at the edge ending cycle T:
  - Cycles T+1 .. T+GAP_CYCLES: state GAP, mux_addr=IDLE_ADDR, active=0.
  - Next SETTLE_CYCLES cycles: state SETTLE, mux_addr=target.
  - Following cycle, T+1+GAP_CYCLES+SETTLE_CYCLES: state ACTIVE, active=1, done=1 for one cycle, cur_addr=target.
  - ow_q captures ow_in on the edge that enters ACTIVE.
- Deselect (IDLE_ADDR requested in ACTIVE):
  - GAP for GAP_CYCLES, then IDLE.
  - On entering IDLE: done=1, cur_addr=IDLE_ADDR, active=0, ow_q=0.
  - No SETTLE phase.
- In ACTIVE, ow_q re-captures ow_in every cycle (one-cycle registered copy). In every other state ow_q holds its value.
- active is 1 only in ACTIVE, and never while mux_addr differs from cur_addr.
- Counter:
  - 8-bit down-counter, loaded with GAP_CYCLES-1 on GAP entry and SETTLE_CYCLES-1 on SETTLE entry.
  - The state advances when the counter is 0.
  - No wrap-around is possible within the legal parameter range.
- Simultaneous events: req_valid is ignored in GAP and SETTLE (ready=0); the request must be held until ready.
- Reset mid-operation: rst in any state immediately forces the reset values above. No done or err pulse is produced for the interrupted request.

Decomposition:
- Shared package mux_pkg holds:
  - the state enum (IDLE, GAP, SETTLE, ACTIVE);
  - the constants ADDR_W, OW_W, IDLE_ADDR;
  - an is_legal_addr() function.
- Natural sub-module: mux_phase_timer, the loadable down-counter with load, value and zero outputs, used for both GAP and SETTLE.
- The FSM, target register and output registers stay in mux_sel_ctrl.

Test Plan:
- Reset release: mux_addr=31, cur_addr=31, active=0, ow_q=0, req_ready=1.
- From IDLE, request addr 2 (defaults, ow_in=24'hA5A5A5), accepted at edge 0:
  - mux_addr=31 for cycles 1-2, mux_addr=2 for cycles 3-6;
  - at cycle 7, active=1, done pulse, cur_addr=2, ow_q=24'hA5A5A5.
- Active on 2, request addr 1: active drops next cycle; 2 gap cycles on 31, then 4 settle cycles on 1, then active=1 and done; req_ready=0 throughout.
- Active on 1:
  - request addr 1: done next cycle, mux_addr stays 1 with no gap;
  - request addr 9: err pulse, active stays 1, cur_addr stays 1.
- Active on 3, request 31: 2 gap cycles, then IDLE with done=1, cur_addr=31, active=0, ow_q=0.
- Assert rst during SETTLE toward addr 0: outputs immediately return to reset values; no done pulse after rst is released.
